mux_2to1_arbiter: RTL and testbench

- Round-robin arbiter that shares one 2:1 data mux between two requesters (A, B).
- Drives the registered mux select and one-hot grants; forwards the selected requester's data.
- A hold limit bounds how long one requester can keep ownership while the other waits.
- Sits in front of any shared single-port resource fed by two sources.

---
 rtl/mux_arb_pkg.sv | 7 +
 rtl/mux_arb_hold_cnt.sv | 18 +
 rtl/mux_2to1_arbiter.sv | 71 +++++++
 tb/tb_mux_2to1_arbiter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared state encoding, select constants and statistics width for the 2:1 mux arbiter
package mux_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, OWN_A = 2'd1, OWN_B = 2'd2} state_t;
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
  localparam int STATS_W = 16;
endpackage

// File: rtl/mux_arb_hold_cnt.sv
// mux_arb_hold_cnt: saturating ownership-length counter; limit_hit marks the last allowed cycle
module mux_arb_hold_cnt #(
  parameter int MAX_HOLD = 4
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic clr_in,
  input  logic en_in,
  output logic limit_hit_out
);
  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) cnt <= '0;
    else if (clr_in) cnt <= '0;
    else if (en_in && int'(cnt) < MAX_HOLD) cnt <= cnt + CNT_W'(1);
  assign limit_hit_out = (MAX_HOLD > 0) && (int'(cnt) >= MAX_HOLD - 1);
endmodule

// File: rtl/mux_2to1_arbiter.sv
// mux_2to1_arbiter: round-robin owner of a shared 2:1 data mux with a hold limit
// Define MUX_ARB_STATS_EN to add saturating per-requester grant counters.
module mux_2to1_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              req_a_in,
  input  logic              req_b_in,
  input  logic [DATA_W-1:0] a_data_in,
  input  logic [DATA_W-1:0] b_data_in,
  output logic              gnt_a_out,
  output logic              gnt_b_out,
  output logic              sel_out,
  output logic              busy_out,
  output logic [DATA_W-1:0] y_data_out
`ifdef MUX_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0] gnt_cnt_a_out,
  output logic [STATS_W-1:0] gnt_cnt_b_out
`endif
);
  state_t st, nxt, idle_nxt, a_nxt, b_nxt;
  logic last_b, limit_hit;
  assign idle_nxt = (req_a_in && req_b_in) ? (last_b ? OWN_A : OWN_B) :
                    req_a_in ? OWN_A : req_b_in ? OWN_B : IDLE;
  // Owner hands over on release or when the other side waits at the limit
  assign a_nxt = (!req_a_in || (req_b_in && limit_hit)) ? (req_b_in ? OWN_B : IDLE) : OWN_A;
  assign b_nxt = (!req_b_in || (req_a_in && limit_hit)) ? (req_a_in ? OWN_A : IDLE) : OWN_B;
  assign nxt = (st == OWN_A) ? a_nxt : (st == OWN_B) ? b_nxt : idle_nxt;
  mux_arb_hold_cnt #(.MAX_HOLD(MAX_HOLD)) u_hold (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .clr_in       (nxt != st || nxt == IDLE),
    .en_in        (st != IDLE),
    .limit_hit_out(limit_hit)
  );
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      st        <= IDLE;
      last_b    <= 1'b1;
      gnt_a_out <= 1'b0;
      gnt_b_out <= 1'b0;
      sel_out   <= SEL_A;
      busy_out  <= 1'b0;
    end else begin
      st        <= nxt;
      if (nxt != IDLE) last_b <= (nxt == OWN_B);
      gnt_a_out <= (nxt == OWN_A);
      gnt_b_out <= (nxt == OWN_B);
      sel_out   <= (nxt == OWN_B) ? SEL_B : SEL_A;
      busy_out  <= (nxt == OWN_A) || (nxt == OWN_B);
    end
  assign y_data_out = sel_out ? b_data_in : a_data_in;
`ifdef MUX_ARB_STATS_EN
  logic ent_a, ent_b;
  assign ent_a = (nxt == OWN_A) && (st != OWN_A);
  assign ent_b = (nxt == OWN_B) && (st != OWN_B);
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      gnt_cnt_a_out <= '0;
      gnt_cnt_b_out <= '0;
    end else begin
      if (ent_a && gnt_cnt_a_out != '1) gnt_cnt_a_out <= gnt_cnt_a_out + STATS_W'(1);
      if (ent_b && gnt_cnt_b_out != '1) gnt_cnt_b_out <= gnt_cnt_b_out + STATS_W'(1);
    end
`endif
endmodule

// File: tb/tb_mux_2to1_arbiter.sv
// tb_mux_2to1_arbiter: directed vectors with hand-computed grants, select and data
module tb_mux_2to1_arbiter;
  logic clk_in = 1'b0, rst_n_in = 1'b0, req_a_in = 1'b0, req_b_in = 1'b0;
  logic [7:0] a_data_in = 8'h5A, b_data_in = 8'hC3, y_data_out;
  logic gnt_a_out, gnt_b_out, sel_out, busy_out;
`ifdef MUX_ARB_STATS_EN
  logic [15:0] gnt_cnt_a_out, gnt_cnt_b_out;
`endif
  int n_vec = 0, n_err = 0;
  always #5 clk_in = ~clk_in;
  mux_2to1_arbiter dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .req_a_in(req_a_in), .req_b_in(req_b_in),
    .a_data_in(a_data_in), .b_data_in(b_data_in), .gnt_a_out(gnt_a_out), .gnt_b_out(gnt_b_out),
    .sel_out(sel_out), .busy_out(busy_out), .y_data_out(y_data_out)
`ifdef MUX_ARB_STATS_EN
    , .gnt_cnt_a_out(gnt_cnt_a_out), .gnt_cnt_b_out(gnt_cnt_b_out)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask
  // {gnt_a, gnt_b, sel, busy}
  task automatic ctl(input string tag, input logic [3:0] exp);
    chk(tag, {gnt_a_out, gnt_b_out, sel_out, busy_out}, exp);
  endtask
  task automatic pulse_rst();
    rst_n_in = 1'b0;
    #2;
    rst_n_in = 1'b1;
  endtask
  initial begin
    #1;
    ctl("reset_ctl", 4'b0000);
    chk("reset_y", y_data_out, 8'h5A);
    step();
    rst_n_in = 1'b1;
    req_a_in = 1'b1;
    #1;
    ctl("a_no_comb_grant", 4'b0000);
    step();
    ctl("a_only_grant", 4'b1001);
    chk("a_only_y", y_data_out, 8'h5A);
    req_a_in = 1'b0;
    step();
    ctl("a_release_idle", 4'b0000);
    pulse_rst();
    req_a_in = 1'b1;
    req_b_in = 1'b1;
    step();
    ctl("tie_a_first", 4'b1001);
    req_a_in = 1'b0;
    step();
    ctl("handover_b", 4'b0111);
    chk("handover_y", y_data_out, 8'hC3);
    req_b_in = 1'b0;
    step();
    ctl("b_release_idle", 4'b0000);
    pulse_rst();
    req_a_in = 1'b1;
    step();
    ctl("hold_a_start", 4'b1001);
    req_b_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      ctl($sformatf("hold_a_%0d", i + 2), 4'b1001);
    end
    step();
    ctl("rotate_to_b", 4'b0111);
    for (int i = 0; i < 3; i++) begin
      step();
      ctl($sformatf("hold_b_%0d", i + 2), 4'b0111);
    end
    step();
    ctl("rotate_to_a", 4'b1001);
    req_a_in = 1'b0;
    req_b_in = 1'b0;
    step();
    ctl("both_release", 4'b0000);
    pulse_rst();
    req_a_in = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      ctl($sformatf("solo_a_%0d", i), 4'b1001);
    end
    req_b_in = 1'b1;
    step();
    ctl("saturated_rotate", 4'b0111);
    chk("saturated_y", y_data_out, 8'hC3);
    rst_n_in = 1'b0;
    #1;
    ctl("async_reset", 4'b0000);
    req_a_in = 1'b0;
    req_b_in = 1'b0;
    step();
    rst_n_in = 1'b1;
    step();
    step();
    ctl("post_reset_idle", 4'b0000);
`ifdef MUX_ARB_STATS_EN
    pulse_rst();
    req_a_in = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      req_a_in = ~req_a_in;
      req_b_in = ~req_b_in;
      step();
    end
    req_a_in = 1'b0;
    req_b_in = 1'b0;
    step();
    chk("stats_a", gnt_cnt_a_out, 16'd3);
    chk("stats_b", gnt_cnt_b_out, 16'd2);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
